// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate_bist engine: FSM state encoding and
// expected-output truth tables for the 2-input gates in the basic-gate library.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit k is the expected gate output for input vector k ({b,a} = k).
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_bist_vecgen.sv
// Vector index and settle timer for gate_bist: holds each vector for SETTLE+1
// cycles and strobes 'sample' on the final cycle of each hold.
module gate_bist_vecgen
  import gate_bist_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en,
  output logic [N_IN-1:0] stim,
  output logic [N_IN-1:0] idx,
  output logic            sample,
  output logic            last
);

  localparam logic [SETTLE_W-1:0] SETTLE_T = SETTLE_W'(SETTLE);
  localparam logic [N_IN-1:0]     IDX_MAX  = {N_IN{1'b1}};

  logic [SETTLE_W-1:0] timer;

  assign sample = en && (timer == SETTLE_T);
  assign last   = sample && (idx == IDX_MAX);
  // The gate sees vector 0 whenever no run is active.
  assign stim   = en ? idx : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      timer <= '0;
    end else if (clear) begin
      idx   <= '0;
      timer <= '0;
    end else if (sample) begin
      timer <= '0;
      // No wrap inside a run: the final sample parks the index at 0.
      idx   <= last ? '0 : idx + N_IN'(1);
    end else if (en) begin
      timer <= timer + SETTLE_W'(1);
    end
  end

endmodule

// File: rtl/gate_bist.sv
// Stimulus-and-check engine for a small combinational gate: walks all input
// vectors, compares the response against TRUTH and reports pass/count/first fail.
// Optional GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]  TRUTH  = 4'b1110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  // 'state' is the observable FSM state for checkers bound to this module.
  state_t          state, state_nxt;
  logic            run_en;
  logic            accept;
  logic            sample;
  logic            last;
  logic            mismatch;
  logic            stop_hit;
  logic            to_done;
  logic [N_IN-1:0] idx;

  assign run_en   = (state == ST_RUN);
  assign accept   = (state == ST_IDLE) && start;
  assign mismatch = sample && (resp != TRUTH[idx]);
  assign to_done  = run_en && (state_nxt == ST_DONE);
  assign busy     = run_en;
  assign done     = (state == ST_DONE);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  gate_bist_vecgen #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vecgen (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .en     (run_en),
    .stim   (stim),
    .idx    (idx),
    .sample (sample),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last || stop_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
    end else if (run_en) begin
      if (mismatch) begin
        err_count <= err_count + (N_IN+1)'(1);
        if (err_count == '0) fail_vec <= idx;
      end
      // The final compare lands on the same edge, so fold it into the verdict.
      if (to_done) pass <= !(mismatch || (err_count != '0));
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: an OR/AND gate model driven by two engine
// instances (SETTLE=1 and SETTLE=3), with hand-computed expected results.
module tb_gate_bist;
  import gate_bist_pkg::*;

  logic       clk;
  logic       rst;
  logic       start1, start3;
  logic       sel3;
  logic       sel_and;
  logic [1:0] stim1, stim3;
  logic       resp1, resp3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [2:0] err1, err3;
  logic [1:0] fv1, fv3;

  int n_checks = 0;
  int n_errors = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test: orgate or andgate, selected per test.
  assign resp1 = sel_and ? (stim1[0] & stim1[1]) : (stim1[0] | stim1[1]);
  assign resp3 = sel_and ? (stim3[0] & stim3[1]) : (stim3[0] | stim3[1]);

  gate_bist #(.N_IN(2), .SETTLE(1), .TRUTH(TT_OR)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  gate_bist #(.N_IN(2), .SETTLE(3), .TRUTH(TT_OR)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stim(stim3), .resp(resp3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3)
  );

  // Observed view of whichever instance the current test targets.
  logic [1:0] o_stim;
  logic       o_busy, o_done, o_pass;
  logic [2:0] o_err;
  logic [1:0] o_fv;
  assign o_stim = sel3 ? stim3 : stim1;
  assign o_busy = sel3 ? busy3 : busy1;
  assign o_done = sel3 ? done3 : done1;
  assign o_pass = sel3 ? pass3 : pass1;
  assign o_err  = sel3 ? err3  : err1;
  assign o_fv   = sel3 ? fv3   : fv1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    start1 = sel3 ? 1'b0 : v;
    start3 = sel3 ? v : 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_stim"}, 32'(o_stim), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_pass"}, 32'(o_pass), 32'd0);
    check({tag, "_err"},  32'(o_err),  32'd0);
    check({tag, "_fv"},   32'(o_fv),   32'd0);
  endtask

  // Cycle c counts from the edge that samples start (c=0 just after it).
  task automatic run_test(input string tag, input bit use3, input bit use_and,
                          input int hold, input int done_cyc, input int exp_err,
                          input int exp_fv, input bit exp_pass, input bit repulse);
    sel3 = use3;
    sel_and = use_and;
    set_start(1'b1);
    step();
    set_start(1'b0);
    for (int c = 0; c <= done_cyc; c++) begin
      if (c == done_cyc) begin
        check({tag, "_done"},  32'(o_done), 32'd1);
        check({tag, "_busy_d"}, 32'(o_busy), 32'd0);
        check({tag, "_stim_d"}, 32'(o_stim), 32'd0);
        check({tag, "_pass"},  32'(o_pass), 32'(exp_pass));
        check({tag, "_err"},   32'(o_err),  32'(exp_err));
        check({tag, "_fv"},    32'(o_fv),   32'(exp_fv));
        if (repulse) set_start(1'b1);
      end else begin
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        check({tag, "_nodone"}, 32'(o_done), 32'd0);
        check({tag, "_stim"}, 32'(o_stim), 32'(c / hold));
        if (repulse && c == 3) set_start(1'b1);
        if (repulse && c == 4) set_start(1'b0);
      end
      step();
    end
    set_start(1'b0);
    check({tag, "_post_done"}, 32'(o_done), 32'd0);
    check({tag, "_post_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_post_pass"}, 32'(o_pass), 32'(exp_pass));
    check({tag, "_post_err"},  32'(o_err),  32'(exp_err));
    step();
    check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    sel3 = 1'b0;
    sel_and = 1'b0;
    repeat (3) step();
    check_idle_zero("rst1");
    sel3 = 1'b1;
    check_idle_zero("rst3");
    sel3 = 1'b0;
    rst = 1'b0;
    step();

    // OR gate vs OR table: stim 0,0,1,1,2,2,3,3 then done.
    run_test("or_s1", 1'b0, 1'b0, 2, 8, 0, 0, 1'b1, 1'b0);

    // AND gate vs OR table: vectors 1 and 2 mismatch.
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    run_test("and_s1", 1'b0, 1'b1, 2, 4, 1, 1, 1'b0, 1'b0);
`else
    run_test("and_s1", 1'b0, 1'b1, 2, 8, 2, 1, 1'b0, 1'b0);
`endif

    // SETTLE=3: four cycles per vector, done after 16 busy cycles.
    run_test("or_s3", 1'b1, 1'b0, 4, 16, 0, 0, 1'b1, 1'b0);

    // Spurious start pulses mid-run and during done are ignored.
    run_test("repulse", 1'b0, 1'b0, 2, 8, 0, 0, 1'b1, 1'b1);

    // Fail run to leave nonzero results, then reset mid-run of a fresh start.
    sel3 = 1'b0;
    sel_and = 1'b1;
    set_start(1'b1);
    step();
    set_start(1'b0);
    repeat (4) step();
    check("mid_busy", 32'(o_busy), 32'd1);
    check("mid_stim", 32'(o_stim), 32'd2);
    rst = 1'b1;
    #1;
    check_idle_zero("midrst");
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("midrst_nodone", 32'(o_done), 32'd0);
      step();
    end
    run_test("after_rst", 1'b0, 1'b0, 2, 8, 0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
# gate_bist

Synthesizable stimulus-and-check engine for the basic-gate library: the hardware counterpart of a gate bench. It walks every input combination of a small combinational gate under test, holds each vector for a programmable settle time and compares the gate output against an expected truth table. It reports pass/fail, an error count and the first failing vector. It sits beside any `andgate`/`orgate`-style gate, driving its inputs and sampling its `y`.

## Interface

**Parameters**
- `N_IN`, default 2: gate input count; vectors are 0 .. 2^N_IN-1.
- `SETTLE`, default 1: extra cycles each vector is held before `resp` is sampled, 0..15.
- `TRUTH`, default 4'b1110 (OR): expected-output table, 2^N_IN bits; bit k is the expected `resp` for vector k.

**Ports**
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a run; accepted only in IDLE.
- `stim`  out  N_IN: vector driven to the gate; `stim[0]`→a, `stim[1]`→b.
- `resp`  in  1: gate output `y`.
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: one-cycle pulse at the end of a run.
- `pass`  out  1: result of the last run; held until the next accepted `start`.
- `err_count`  out  N_IN+1: number of mismatching vectors in the last run.
- `fail_vec`  out  N_IN: first mismatching vector; 0 when `pass`=1.

## Operation

- **Reset state:** FSM IDLE, `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0.
- **FSM states:** IDLE → RUN → DONE → IDLE.
- **IDLE:**
  - `start`=1 → RUN.
  - On entering RUN: vector index=0, settle timer=0, `err_count` cleared, `fail_vec` cleared, `pass` cleared.
- **RUN:**
  - `stim` = vector index.
  - The settle timer counts 0..SETTLE.
  - When the timer equals SETTLE, `resp` is compared with `TRUTH[index]`:
    - On a mismatch, `err_count`+1.
    - On the first mismatch, `fail_vec`=index.
  - The index then increments and the timer clears.
  - After the compare of index 2^N_IN-1 → DONE. The index does not wrap inside a run.
- **DONE:**
  - Lasts exactly one cycle.
  - `done`=1, `busy`=0.
  - `pass` = (`err_count`==0), registered in this cycle.
  - `stim` returns to 0.
  - Then → IDLE.
- **`start` outside IDLE** (in RUN or DONE): ignored, no effect.
- **`rst` mid-run:** immediate return to the reset state. The partial result is discarded and `done` is not pulsed.
- **Counter width:** `err_count` cannot overflow, since its maximum is 2^N_IN and it has N_IN+1 bits.

## Timing

- `start` sampled high at edge E0:
  - `busy`=1 and `stim`=0 from E0.
  - Vector k is sampled at edge E0+(k+1)(SETTLE+1).
- `done` is high for the cycle after the last sample. With N_IN=2 and SETTLE=1, that is edges E8–E9.
- Run length = 2^N_IN·(SETTLE+1) cycles of `busy`, plus 1 cycle of DONE.
- `resp` is registered only at the sample edge, so the gate path gets SETTLE+1 cycles to settle.
- `pass`, `err_count` and `fail_vec` are final and valid from the `done` cycle onward.

## Configuration

- Macro: `GATE_BIST_STOP_ON_FAIL_EN`.
- **Defined:** the first mismatch ends RUN immediately → DONE on the next cycle. `err_count`=1 and `fail_vec` = the failing index.
- **Undefined (default):** all vectors are always exercised, and `err_count` is the full mismatch total.

## Structure

- **Package `gate_bist_pkg`:**
  - FSM state enum (IDLE, RUN, DONE).
  - Truth-table constants for 2-input gates: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- **Sub-module `gate_bist_vecgen`:** vector index plus settle timer. Outputs `stim`, `sample` strobe and `last` flag. The top level holds the FSM, compare logic and result registers.

## Test plan

- `orgate` DUT, TRUTH=TT_OR, SETTLE=1, `start` pulse → `stim` sequence 0,0,1,1,2,2,3,3; `done` at cycle 9; `pass`=1, `err_count`=0, `fail_vec`=0.
- `andgate` DUT, TRUTH=TT_OR → mismatches at vectors 1 and 2; `pass`=0, `err_count`=2, `fail_vec`=1.
- Same as the previous case with `GATE_BIST_STOP_ON_FAIL_EN` defined → `done` right after the vector-1 sample (cycle 5); `err_count`=1, `fail_vec`=1.
- SETTLE=3, `orgate` DUT → each vector held 4 cycles; `busy` for 16 cycles, `done` at cycle 17, `pass`=1.
- `start` re-pulsed at cycle 3 of a run, and again during `done` → run length and results unchanged.
- `rst` asserted at cycle 4 of a run → all outputs 0 immediately, no `done`. A fresh `start` then yields a normal passing run.
